// File: rtl/hdlverifier_sync_fifo_lvl.sv
// Single-clock FIFO using all 2**ADDR_WIDTH entries, with occupancy count, thresholds and sticky error flags.
// Define HDLV_SYNC_FIFO_FWFT_EN for first-word-fall-through mode; by default rdata is registered.
module hdlverifier_sync_fifo_lvl #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned AFULL_THRESH  = 2**ADDR_WIDTH - 4,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  aclr_n,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wrreq,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  rdreq,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  wr_ok, rd_ok;

    // Acceptance, pointer/count update and flags derived from the next count.
    always_comb begin
        wr_ok   = wrreq && (!full_q || rdreq);
        rd_ok   = rdreq && !empty_q;
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        if (wr_ok) waddr_d = waddr_q + ADDR_WIDTH'(1);
        if (rd_ok) raddr_d = raddr_q + ADDR_WIDTH'(1);
        count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == CW'(0));
        afull_d  = (count_d >= CW'(AFULL_THRESH));
        aempty_d = (count_d <= CW'(AEMPTY_THRESH));
        // A new error event in the same cycle as err_clr wins.
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wrreq && full_q && !rdreq) ovf_d = 1'b1;
        if (rdreq && empty_q)          udf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            waddr_q  <= '0;
            raddr_q  <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= (AFULL_THRESH == 0);
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[waddr_q] <= wdata;
    end

`ifdef HDLV_SYNC_FIFO_FWFT_EN
    assign rdata = mem[raddr_q];
`else
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (rd_ok) rdata_d = mem[raddr_q];
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) rdata_q <= '0;
        else         rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_hdlverifier_sync_fifo_lvl.sv
// Self-checking bench for hdlverifier_sync_fifo_lvl against a queue-based reference model.
module tb_hdlverifier_sync_fifo_lvl;

    localparam int DW     = 32;
    localparam int AW     = 8;
    localparam int DEPTH  = 256;
    localparam int AFULL  = DEPTH - 4;
    localparam int AEMPTY = 4;

    logic          clk = 1'b0;
    logic          aclr_n = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          wrreq = 1'b0;
    logic          rdreq = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] rdata;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]   count;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rdata;
    logic          m_ovf, m_udf;

    hdlverifier_sync_fifo_lvl dut (
        .clk(clk), .aclr_n(aclr_n), .wdata(wdata), .wrreq(wrreq), .rdata(rdata),
        .rdreq(rdreq), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the reference model advances by the FIFO's rules.
    task automatic step(input logic wr, input logic rd, input logic [DW-1:0] wd, input logic clr);
        bit full_m, empty_m, do_rd, do_wr;
        full_m  = (mq.size() == DEPTH);
        empty_m = (mq.size() == 0);
        do_rd   = rd && !empty_m;
        do_wr   = wr && (!full_m || rd);
        wrreq = wr; rdreq = rd; wdata = wd; err_clr = clr;
        @(posedge clk);
        if (do_rd) m_rdata = mq.pop_front();
        if (do_wr) mq.push_back(wd);
        if (clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
        if (wr && full_m && !rd) m_ovf = 1'b1;
        if (rd && empty_m) m_udf = 1'b1;
        #1;
        wrreq = 1'b0; rdreq = 1'b0; err_clr = 1'b0;
    endtask

    task automatic apply_reset();
        aclr_n = 1'b0;
        @(negedge clk);
        aclr_n = 1'b1;
        mq.delete();
        m_rdata = '0; m_ovf = 1'b0; m_udf = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        aclr_n = 1'b0;
        #12;
        total++; if (count !== 0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_aempty: got %b want 1", almost_empty); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_afull: got %b want 0", almost_full); end
        total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL reset_err: got %b%b want 00", overflow, underflow); end
`ifndef HDLV_SYNC_FIFO_FWFT_EN
        total++; if (rdata !== '0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
`endif
        apply_reset();
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, DW'(i), 1'b0);
            total++; if (count !== (AW+1)'(mq.size())) begin bad++; $display("FAIL fill_count: got %0d want %0d", count, mq.size()); end
            total++; if (almost_full !== (mq.size() >= AFULL)) begin bad++; $display("FAIL fill_afull: got %b at count %0d", almost_full, mq.size()); end
            total++; if (almost_empty !== (mq.size() <= AEMPTY)) begin bad++; $display("FAIL fill_aempty: got %b at count %0d", almost_empty, mq.size()); end
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full: got %b want 1", full); end
        total++; if (count !== 9'd256) begin bad++; $display("FAIL fill_count256: got %0d want 256", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_overflow_drain();
        step(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        total++; if (count !== 9'd256) begin bad++; $display("FAIL ovf_count: got %0d want 256", count); end
        for (int i = 0; i < DEPTH; i++) begin
`ifdef HDLV_SYNC_FIFO_FWFT_EN
            total++; if (rdata !== DW'(i)) begin bad++; $display("FAIL drain_data: got %h want %h", rdata, DW'(i)); end
            step(1'b0, 1'b1, '0, 1'b0);
`else
            step(1'b0, 1'b1, '0, 1'b0);
            total++; if (rdata !== DW'(i)) begin bad++; $display("FAIL drain_data: got %h want %h", rdata, DW'(i)); end
`endif
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %b want 1", empty); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL drain_udf: got %b want 0", underflow); end
        step(1'b0, 1'b0, '0, 1'b1);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL errclr_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_empty_rw();
        step(1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0);
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL erw_udf: got %b want 1", underflow); end
        total++; if (count !== 9'd1) begin bad++; $display("FAIL erw_count: got %0d want 1", count); end
`ifdef HDLV_SYNC_FIFO_FWFT_EN
        total++; if (rdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL erw_data: got %h want a5a5a5a5", rdata); end
        step(1'b0, 1'b1, '0, 1'b0);
`else
        total++; if (rdata !== m_rdata) begin bad++; $display("FAIL erw_hold: got %h want %h", rdata, m_rdata); end
        step(1'b0, 1'b1, '0, 1'b0);
        total++; if (rdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL erw_data: got %h want a5a5a5a5", rdata); end
`endif
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL erw_empty: got %b want 1", empty); end
        step(1'b0, 1'b0, '0, 1'b1);
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL erw_clr: got %b want 0", underflow); end
    endtask

    task automatic test_full_stream();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 32'h1000 + DW'(i), 1'b0);
        for (int k = 0; k < 300; k++) begin
`ifdef HDLV_SYNC_FIFO_FWFT_EN
            total++; if (rdata !== 32'h1000 + DW'(k)) begin bad++; $display("FAIL stream_data: got %h want %h", rdata, 32'h1000 + DW'(k)); end
            step(1'b1, 1'b1, 32'h1100 + DW'(k), 1'b0);
`else
            step(1'b1, 1'b1, 32'h1100 + DW'(k), 1'b0);
            total++; if (rdata !== 32'h1000 + DW'(k)) begin bad++; $display("FAIL stream_data: got %h want %h", rdata, 32'h1000 + DW'(k)); end
`endif
            total++; if (count !== 9'd256 || full !== 1'b1) begin bad++; $display("FAIL stream_count: got %0d full %b want 256 full 1", count, full); end
        end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL stream_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h5000 + DW'(i), 1'b0);
        #2 aclr_n = 1'b0;
        #1;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL areset_empty: got %b want 1", empty); end
        total++; if (count !== 0) begin bad++; $display("FAIL areset_count: got %0d want 0", count); end
        @(negedge clk);
        aclr_n = 1'b1;
        mq.delete();
        m_rdata = '0; m_ovf = 1'b0; m_udf = 1'b0;
        for (int i = 5; i < 10; i++) step(1'b1, 1'b0, 32'hBEEF_0000 + DW'(i), 1'b0);
        total++; if (count !== 9'd5) begin bad++; $display("FAIL areset_refill: got %0d want 5", count); end
`ifdef HDLV_SYNC_FIFO_FWFT_EN
        total++; if (rdata !== 32'hBEEF_0005) begin bad++; $display("FAIL areset_data: got %h want beef0005", rdata); end
        step(1'b0, 1'b1, '0, 1'b0);
`else
        step(1'b0, 1'b1, '0, 1'b0);
        total++; if (rdata !== 32'hBEEF_0005) begin bad++; $display("FAIL areset_data: got %h want beef0005", rdata); end
`endif
    endtask

    task automatic test_random();
        bit wr, rd, clr;
        apply_reset();
        for (int i = 0; i < 2800; i++) begin
            if (((i / 700) % 2) == 0) begin
                wr = ($urandom_range(99) < 75); rd = ($urandom_range(99) < 35);
            end else begin
                wr = ($urandom_range(99) < 30); rd = ($urandom_range(99) < 75);
            end
            clr = ($urandom_range(99) < 3);
            step(wr, rd, $urandom(), clr);
            total++;
            if (count !== (AW+1)'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) ||
                almost_full !== (mq.size() >= AFULL) || almost_empty !== (mq.size() <= AEMPTY) ||
                overflow !== m_ovf || underflow !== m_udf) begin
                bad++;
                $display("FAIL rand_flags: cyc %0d got cnt=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b want cnt=%0d ov=%b un=%b",
                         i, count, full, empty, almost_full, almost_empty, overflow, underflow, mq.size(), m_ovf, m_udf);
            end
`ifdef HDLV_SYNC_FIFO_FWFT_EN
            if (mq.size() > 0) begin
                total++; if (rdata !== mq[0]) begin bad++; $display("FAIL rand_data: cyc %0d got %h want %h", i, rdata, mq[0]); end
            end
`else
            total++; if (rdata !== m_rdata) begin bad++; $display("FAIL rand_data: cyc %0d got %h want %h", i, rdata, m_rdata); end
`endif
        end
    endtask

`ifdef HDLV_SYNC_FIFO_FWFT_EN
    task automatic test_fwft();
        apply_reset();
        step(1'b1, 1'b0, 32'h1234_5678, 1'b0);
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL fwft_empty: got %b want 0", empty); end
        total++; if (rdata !== 32'h1234_5678) begin bad++; $display("FAIL fwft_first: got %h want 12345678", rdata); end
        step(1'b1, 1'b0, 32'h9ABC_DEF0, 1'b0);
        total++; if (rdata !== 32'h1234_5678) begin bad++; $display("FAIL fwft_hold: got %h want 12345678", rdata); end
        step(1'b0, 1'b1, '0, 1'b0);
        total++; if (rdata !== 32'h9ABC_DEF0) begin bad++; $display("FAIL fwft_second: got %h want 9abcdef0", rdata); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_empty_rw();
        test_full_stream();
        test_async_reset();
        test_random();
`ifdef HDLV_SYNC_FIFO_FWFT_EN
        test_fwft();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
